// File: rtl/uart_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_monitor
//  Description : 8N1 UART receiver that snoops an SoC tx line and queues the
//                received bytes in a first-word-fall-through FIFO.
//                Optional even-parity checking (8E1) is enabled by defining
//                the macro UART_RX_MONITOR_PARITY_EN.
//  Parameters  : CLKS_PER_BIT  clock cycles per serial bit (4..65535)
//                FIFO_DEPTH    receive FIFO entries (power of two, 2..256)
//  Ports       : clk        sole clock, rising edge
//                rst        asynchronous active-high reset
//                rx         serial input, idle high
//                data       byte at FIFO head (0 while FIFO empty)
//                valid      FIFO non-empty
//                ready      consumer accepts head byte (pop on valid&ready)
//                level      current FIFO occupancy
//                frame_err  one-cycle pulse on bad stop (or parity) bit
//                overrun    one-cycle pulse when a byte is dropped (FIFO full)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int                  c_ADDR_W    = $clog2(FIFO_DEPTH);
    localparam logic [15:0]         c_HALF_M1   = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]         c_FULL_M1   = 16'(CLKS_PER_BIT - 1);
    localparam logic [c_ADDR_W:0]   c_LVL_FULL  = FIFO_DEPTH[c_ADDR_W:0];
    localparam logic [c_ADDR_W:0]   c_LVL_ONE   = 1;
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE   = 1;

`ifdef UART_RX_MONITOR_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Input synchronizer. r_flush marks when the synchronizer holds real
    // line samples rather than its reset value, so a line held low across
    // reset is not mistaken for a high-then-falling start edge.
    // ------------------------------------------------------------------
    logic       r_rx_meta;
    logic       r_rx_s;
    logic [1:0] r_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_flush   <= 2'b00;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_flush   <= {r_flush[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t      r_state, w_state_n;
    logic [15:0] r_cnt,   w_cnt_n;
    logic [2:0]  r_bit,   w_bit_n;
    logic [7:0]  r_sh,    w_sh_n;
    // r_armed: the line has been seen high while idle; the next low level
    // is then a genuine falling edge. Cleared on frame start and on frame
    // error so a stuck-low line cannot retrigger.
    logic        r_armed, w_armed_n;
    logic        w_push;
    logic        w_ferr_n;
`ifdef UART_RX_MONITOR_PARITY_EN
    logic        r_perr,  w_perr_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_sh    <= 8'h00;
            r_armed <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_sh    <= w_sh_n;
            r_armed <= w_armed_n;
`ifdef UART_RX_MONITOR_PARITY_EN
            r_perr  <= w_perr_n;
`endif
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 16'd1;
        w_bit_n   = r_bit;
        w_sh_n    = r_sh;
        w_armed_n = r_armed;
        w_push    = 1'b0;
        w_ferr_n  = 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
        w_perr_n  = r_perr;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_n = 16'd0;
                w_bit_n = 3'd0;
                if (r_flush[1] && r_rx_s)
                    w_armed_n = 1'b1;
                if (r_armed && !r_rx_s) begin
                    w_state_n = START;
                    w_armed_n = 1'b0;
                end
            end
            START: begin
                // Mid-start-bit check rejects short glitches
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_n = 16'd0;
                    if (r_rx_s)
                        w_state_n = IDLE;
                    else
                        w_state_n = DATA;
                end
            end
            DATA: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_n = 16'd0;
                    w_sh_n  = {r_rx_s, r_sh[7:1]};
                    w_bit_n = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_MONITOR_PARITY_EN
                        w_state_n = PARITY;
`else
                        w_state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_MONITOR_PARITY_EN
            PARITY: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_n   = 16'd0;
                    // Even parity: data bits plus parity bit have an even count of ones
                    w_perr_n  = r_rx_s ^ (^r_sh);
                    w_state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_n   = 16'd0;
                    w_state_n = IDLE;
`ifdef UART_RX_MONITOR_PARITY_EN
                    if (r_rx_s && !r_perr)
`else
                    if (r_rx_s)
`endif
                        w_push = 1'b1;
                    else begin
                        w_ferr_n  = 1'b1;
                        w_armed_n = 1'b0;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = 16'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_level;
    logic                r_frame_err;
    logic                r_overrun;
    logic                w_full;
    logic                w_pop;
    logic                w_accept;

    assign valid     = (r_level != '0);
    assign level     = r_level;
    assign data      = valid ? r_mem[r_rd_ptr] : 8'h00;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    assign w_full    = (r_level == c_LVL_FULL);
    assign w_pop     = valid && ready;
    // A pop in the same cycle frees the slot the new byte needs
    assign w_accept  = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_accept)
            r_mem[r_wr_ptr] <= r_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr_n;
            r_overrun   <= w_push && !w_accept;
            if (w_accept)
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_monitor
//  Description : Directed, table-driven bench for uart_rx_monitor
//                (CLKS_PER_BIT=16, FIFO_DEPTH=4). Follows the
//                UART_RX_MONITOR_PARITY_EN macro to frame with parity.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_monitor;

    localparam int c_CPB   = 16;
    localparam int c_DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [2:0] level;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_monitor #(
        .CLKS_PER_BIT (c_CPB),
        .FIFO_DEPTH   (c_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .level     (level),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       par_flip;
        logic       rdy;
        logic [2:0] exp_level;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_ovr;
        int         drain;
    } vec_t;

`ifdef UART_RX_MONITOR_PARITY_EN
    localparam int c_NVEC = 15;
    localparam int c_NPOP = 11;
`else
    localparam int c_NVEC = 13;
    localparam int c_NPOP = 10;
`endif

    vec_t       vecs [c_NVEC];
    logic [7:0] pop_exp [c_NPOP];
    int         pidx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame starting just after a clock edge and returns #1 after
    // the stop-bit sample edge. ready is held high only during the cycle
    // that ends at the stop-bit sample edge when rdy is set.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic flip, input logic rdy);
        rx = 1'b0;
        repeat (c_CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (c_CPB) @(posedge clk);
            #1;
        end
`ifdef UART_RX_MONITOR_PARITY_EN
        rx = (^b) ^ flip;
        repeat (c_CPB) @(posedge clk);
        #1;
`else
        if (flip) rx = 1'b1;
`endif
        rx = stop;
        repeat (c_CPB - 6) @(posedge clk);
        #1;
        ready = rdy;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            check({tag, " pop valid"}, {31'd0, valid}, 32'd1);
            check({tag, " pop data"}, {24'd0, data}, {24'd0, pop_exp[pidx]});
            pidx++;
            ready = 1'b1;
            @(posedge clk);
            #1;
            ready = 1'b0;
        end
        check({tag, " drained level"}, {29'd0, level}, 32'd0);
        check({tag, " drained data"}, {24'd0, data}, 32'd0);
    endtask

    initial begin
        logic seen;

        vecs[0]  = '{8'h55, 1'b1, 1'b0, 1'b0, 3'd1, 8'h55, 1'b0, 1'b0, 1};
        vecs[1]  = '{8'hA3, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 0};
        vecs[2]  = '{8'h12, 1'b1, 1'b0, 1'b0, 3'd1, 8'h12, 1'b0, 1'b0, 1};
        vecs[3]  = '{8'h01, 1'b1, 1'b0, 1'b0, 3'd1, 8'h01, 1'b0, 1'b0, 0};
        vecs[4]  = '{8'h02, 1'b1, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0, 1'b0, 0};
        vecs[5]  = '{8'h03, 1'b1, 1'b0, 1'b0, 3'd3, 8'h01, 1'b0, 1'b0, 0};
        vecs[6]  = '{8'h04, 1'b1, 1'b0, 1'b0, 3'd4, 8'h01, 1'b0, 1'b0, 0};
        vecs[7]  = '{8'h05, 1'b1, 1'b0, 1'b0, 3'd4, 8'h01, 1'b0, 1'b1, 4};
        vecs[8]  = '{8'h21, 1'b1, 1'b0, 1'b0, 3'd1, 8'h21, 1'b0, 1'b0, 0};
        vecs[9]  = '{8'h22, 1'b1, 1'b0, 1'b0, 3'd2, 8'h21, 1'b0, 1'b0, 0};
        vecs[10] = '{8'h23, 1'b1, 1'b0, 1'b0, 3'd3, 8'h21, 1'b0, 1'b0, 0};
        vecs[11] = '{8'h24, 1'b1, 1'b0, 1'b0, 3'd4, 8'h21, 1'b0, 1'b0, 0};
        vecs[12] = '{8'h06, 1'b1, 1'b0, 1'b1, 3'd4, 8'h22, 1'b0, 1'b0, 4};
`ifdef UART_RX_MONITOR_PARITY_EN
        vecs[13] = '{8'h07, 1'b1, 1'b0, 1'b0, 3'd1, 8'h07, 1'b0, 1'b0, 1};
        vecs[14] = '{8'h07, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 0};
`endif
        pop_exp[0] = 8'h55;
        pop_exp[1] = 8'h12;
        pop_exp[2] = 8'h01;
        pop_exp[3] = 8'h02;
        pop_exp[4] = 8'h03;
        pop_exp[5] = 8'h04;
        pop_exp[6] = 8'h22;
        pop_exp[7] = 8'h23;
        pop_exp[8] = 8'h24;
        pop_exp[9] = 8'h06;
`ifdef UART_RX_MONITOR_PARITY_EN
        pop_exp[10] = 8'h07;
`endif

        // ---------------- reset ----------------
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst valid", {31'd0, valid}, 32'd0);
        check("rst level", {29'd0, level}, 32'd0);
        check("rst data", {24'd0, data}, 32'd0);
        check("rst frame_err", {31'd0, frame_err}, 32'd0);
        check("rst overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post-rst valid", {31'd0, valid}, 32'd0);
        check("post-rst level", {29'd0, level}, 32'd0);

        // ---------------- 5-cycle glitch ----------------
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (frame_err || valid) seen = 1'b1;
        end
        check("glitch no output", {31'd0, seen}, 32'd0);
        check("glitch level", {29'd0, level}, 32'd0);

        // ---------------- frame table ----------------
        for (int v = 0; v < c_NVEC; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            send_frame(vecs[v].b, vecs[v].stop, vecs[v].par_flip, vecs[v].rdy);
            check({tag, " level"}, {29'd0, level}, {29'd0, vecs[v].exp_level});
            check({tag, " valid"}, {31'd0, valid}, {31'd0, (vecs[v].exp_level != 3'd0)});
            check({tag, " data"}, {24'd0, data}, {24'd0, vecs[v].exp_data});
            check({tag, " frame_err"}, {31'd0, frame_err}, {31'd0, vecs[v].exp_ferr});
            check({tag, " overrun"}, {31'd0, overrun}, {31'd0, vecs[v].exp_ovr});
            @(posedge clk);
            #1;
            check({tag, " frame_err pulse end"}, {31'd0, frame_err}, 32'd0);
            check({tag, " overrun pulse end"}, {31'd0, overrun}, 32'd0);
            check({tag, " level held"}, {29'd0, level}, {29'd0, vecs[v].exp_level});
            repeat (4) @(posedge clk);
            #1;
            rx = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            if (vecs[v].drain > 0)
                drain(vecs[v].drain, tag);
        end

        // ---------------- reset mid-frame, line held low ----------------
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b1;
        #4;
        check("midrst level", {29'd0, level}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (220) begin
            @(posedge clk);
            #1;
            if (frame_err || valid) seen = 1'b1;
        end
        check("midrst low line ignored", {31'd0, seen}, 32'd0);
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check("midrst next frame level", {29'd0, level}, 32'd1);
        check("midrst next frame data", {24'd0, data}, 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal values 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx, input, 1, serial line driven by the SoC uart tx pin, idle high.
REQ-006 SHALL have port data, output, 8, byte at FIFO head.
REQ-007 SHALL have port valid, output, 1, FIFO non-empty.
REQ-008 SHALL have port ready, input, 1, consumer accepts head byte.
REQ-009 SHALL have port level, output, clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse on byte dropped because the FIFO is full.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer, both flops reset to 1; all decoding uses the synchronized value (rx_s).
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-030).
REQ-014 IDLE -> START SHALL occur on rx_s falling edge (previous 1, current 0); the bit counter clears to 0.
REQ-015 START SHALL sample rx_s when the counter reaches CLKS_PER_BIT/2-1 (integer division); sample 1 -> IDLE (glitch, no output), sample 0 -> DATA with counter cleared.
REQ-016 DATA SHALL sample rx_s each time the counter reaches CLKS_PER_BIT-1, counter wraps to 0, shifting 8 bits LSB first, then -> STOP.
REQ-017 STOP SHALL sample after CLKS_PER_BIT cycles; sample 1 pushes the byte into the FIFO in that same cycle; sample 0 pulses frame_err, discards the byte; both -> IDLE.
REQ-018 After a frame error the FSM SHALL NOT restart until rx_s is seen high and then falls again.
REQ-019 FIFO SHALL be first-word-fall-through: valid = (level != 0), data = head entry combinationally.
REQ-020 Pop SHALL occur when valid and ready are both 1 at a rising edge; ready while !valid has no effect.
REQ-021 A pushed byte SHALL appear with valid=1 on the cycle after the stop-bit sample (1-cycle latency).
REQ-022 Push when full SHALL be accepted if a pop occurs the same cycle (level unchanged); otherwise the byte is dropped, overrun pulses, and FIFO contents stay intact.
REQ-023 Simultaneous push and pop when not full SHALL leave level unchanged.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH.
REQ-025 frame_err and overrun SHALL be registered, high for exactly one cycle per event.

Reset
REQ-026 rst SHALL asynchronously force FSM to IDLE, counters and shift register to 0, synchronizer flops to 1, FIFO pointers to 0.
REQ-027 During and after reset: valid=0, level=0, data=0, frame_err=0, overrun=0.
REQ-028 A reset mid-frame SHALL abandon the frame; a line still low after release SHALL NOT start a frame until high-then-falling is seen.
REQ-029 FIFO storage contents need not be reset; data SHALL read 0 whenever valid=0.

Configuration
REQ-030 Macro UART_RX_MONITOR_PARITY_EN defined: state PARITY follows DATA, samples one even-parity bit after CLKS_PER_BIT cycles; mismatch pulses frame_err and discards the byte at STOP regardless of stop value.
REQ-031 Macro undefined: no PARITY state, 8N1 framing, DATA -> STOP directly.

Verification (bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-032 Reset, then frame 0x55 8N1 on rx -> valid=1, data=0x55, level=1 one cycle after stop sample; ready=1 -> level=0.
REQ-033 Low pulse of 5 cycles on idle rx -> no push, no frame_err, FSM back in IDLE.
REQ-034 Frame 0xA3 with stop bit 0 -> frame_err high 1 cycle, level stays 0; next good frame 0x12 received correctly.
REQ-035 Five frames 0x01..0x05 with ready=0 -> level=4, overrun pulses once at fifth stop sample; pops yield 0x01..0x04.
REQ-036 FIFO full, ready=1 held on the stop-sample cycle of a sixth frame 0x06 -> no overrun, level stays 4, last entry 0x06.
REQ-037 With UART_RX_MONITOR_PARITY_EN: 0x07 with parity 1 -> accepted; 0x07 with parity 0 -> frame_err, no push.
